// File: rtl/risc_issue_pkg.sv
// Shared types and constants for the instruction issuer and its program RAM.
package risc_issue_pkg;

  localparam int INSTR_W         = 16;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LOAD    = 3'd2,
    S_START   = 3'd3,
    S_EXEC_LO = 3'd4,
    S_EXEC_HI = 3'd5,
    S_DONE    = 3'd6
  } issue_state_t;

endpackage

// File: rtl/prog_ram.sv
// Program store: DEPTH x INSTR_W, one synchronous write port and one synchronous read port.
module prog_ram
  import risc_issue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] rdata_q;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port forwards a same-cycle write so a run launched together with a write sees the new word.
  always_ff @(posedge clk) begin
    if (re) begin
      if (we && (waddr == raddr)) begin
        rdata_q <= wdata;
      end else begin
        rdata_q <= mem_q[raddr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_issuer.sv
// Issues a stored program to the cpu over the in/load/s/w handshake, one instruction at a time,
// waiting for w to drop and rise again before fetching the next word.
module instr_issuer
  import risc_issue_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH),
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic [AW:0]        len,
  input  logic               w,
  output logic [INSTR_W-1:0] in,
  output logic               load,
  output logic               s,
  output logic [AW-1:0]      pc,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  issue_state_t       state_q,  state_d;
  logic [AW-1:0]      pc_q,     pc_d;
  logic [AW:0]        issued_q, issued_d;
  logic [AW:0]        len_q,    len_d;
  logic [TW-1:0]      tmo_q,    tmo_d;
  logic [INSTR_W-1:0] in_q,     in_d;
  logic               load_q,   load_d;
  logic               s_q,      s_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic               err_q,    err_d;

  logic               ram_we_s;
  logic               ram_re_s;
  logic [AW-1:0]      ram_raddr_s;
  logic [INSTR_W-1:0] ram_rdata_s;

  assign ram_we_s = prog_we && (state_q == S_IDLE);

  prog_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (ram_re_s),
    .raddr (ram_raddr_s),
    .rdata (ram_rdata_s)
  );

  // Next-state, counters and registered-output values; outputs are decoded from the state being entered.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    issued_d = issued_q;
    len_d    = len_q;
    tmo_d    = tmo_q;
    in_d     = in_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d    = len;
          pc_d     = '0;
          issued_d = '0;
          tmo_d    = '0;
          err_d    = 1'b0;
          state_d  = (len == '0) ? S_DONE : S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        in_d    = ram_rdata_s;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_START;
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_EXEC_LO;
      end
      S_EXEC_LO: begin
        if (!w) begin
          tmo_d   = '0;
          state_d = S_EXEC_HI;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      S_EXEC_HI: begin
        if (w) begin
          issued_d = issued_q + {{AW{1'b0}}, 1'b1};
          pc_d     = pc_q + {{(AW-1){1'b0}}, 1'b1};
          state_d  = (issued_d == len_q) ? S_DONE : S_FETCH;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The read is launched on the edge into FETCH so the word is on rdata during FETCH.
    ram_re_s    = (state_d == S_FETCH);
    ram_raddr_s = pc_d;

    load_d = (state_d == S_LOAD);
    s_d    = (state_d == S_START);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      issued_q <= '0;
      len_q    <= '0;
      tmo_q    <= '0;
      in_q     <= '0;
      load_q   <= 1'b0;
      s_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      issued_q <= issued_d;
      len_q    <= len_d;
      tmo_q    <= tmo_d;
      in_q     <= in_d;
      load_q   <= load_d;
      s_q      <= s_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign in   = in_q;
  assign load = load_q;
  assign s    = s_q;
  assign pc   = pc_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
